// File: rtl/eau_pkg.sv
// Shared vector geometry and array types for the element boundary unit and eau.
// Lane count, lane width and length-field width all derive from VLEN/BSW.
package eau_pkg;
  localparam int VLEN = 256;
  localparam int BSW  = 5;
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  localparam int LMAX = 8;
  localparam int WW   = 8 - BSW + 1;

  typedef logic [BLEN-1:0] lane_t;
  typedef lane_t [BS-1:0]  lane_arr_t;
  typedef logic [WW-1:0]   len_t;
  typedef len_t [BS-1:0]   len_arr_t;
  typedef logic [BSW-1:0]  pos_t;
  typedef pos_t [BS-1:0]   pos_arr_t;
  typedef logic [BSW:0]    cnt_t;
endpackage

// File: rtl/ebu_if.sv
// Beat-in / element-out bundle of one ebu instance.
// Handshake: a beat moves on a side when its valid and ready are both high at a rising clk edge.
interface ebu_if;
  import eau_pkg::*;

  logic             ivalid;
  logic             iready;
  logic [BS-1:0]    imask;
  cnt_t             ibytes;
  lane_arr_t        idata;
  logic             ovalid;
  logic             oready;
  cnt_t             onum;
  len_arr_t         olen;
  pos_arr_t         opos;
  lane_arr_t        odata;
  logic             oerr;

  modport slave (
    input  ivalid, imask, ibytes, idata, oready,
    output iready, ovalid, onum, olen, opos, odata, oerr
  );

  modport master (
    output ivalid, imask, ibytes, idata, oready,
    input  iready, ovalid, onum, olen, opos, odata, oerr
  );
endinterface

// File: rtl/ebu_rank.sv
// Combinational prefix popcount: o_rank[i] = number of set bits strictly below lane i.
// o_total is the full popcount, which becomes the element count.
module ebu_rank
  import eau_pkg::*;
(
  input  logic [BS-1:0] i_mask,
  output pos_arr_t      o_rank,
  output cnt_t          o_total
);
  cnt_t w_acc;

  always_comb begin
    w_acc  = '0;
    o_rank = '0;
    for (int i = 0; i < BS; i++) begin
      o_rank[i] = w_acc[BSW-1:0];
      w_acc     = w_acc + cnt_t'(i_mask[i]);
    end
    o_total = w_acc;
  end
endmodule

// File: rtl/ebu.sv
// Element boundary unit: 2-stage elastic pipeline turning a start-of-element mask
// into compacted per-element start lanes and lengths for eau.
module ebu
  import eau_pkg::*;
(
  input logic   clk,
  input logic   rst,
  ebu_if.slave  io
);
  cnt_t          w_nb;
  logic [BS-1:0] w_lanes;
  logic [BS-1:0] w_emask;
  logic          w_err_in;
  pos_arr_t      w_rank;
  cnt_t          w_total;
  logic          w_adv;
  logic          w_iready;

  logic          r_v1;
  logic [BS-1:0] r_emask;
  cnt_t          r_nb;
  lane_arr_t     r_data;
  logic          r_err;
  pos_arr_t      r_rank;
  cnt_t          r_total;

  logic          r_v2;
  cnt_t          r_onum;
  len_arr_t      r_olen;
  pos_arr_t      r_opos;
  lane_arr_t     r_odata;
  logic          r_oerr;

  len_arr_t      w_len;
  pos_arr_t      w_pos;
  logic          w_len_err;
  cnt_t          w_next;
  cnt_t          w_full;

  // Oversized ibytes clamps to BS; an empty beat never flags a mask error.
  always_comb begin
    w_nb = (io.ibytes > cnt_t'(BS)) ? cnt_t'(BS) : io.ibytes;
    for (int i = 0; i < BS; i++) begin
      w_lanes[i] = (cnt_t'(i) < w_nb);
    end
    w_emask  = io.imask & w_lanes;
    w_err_in = (io.ibytes > cnt_t'(BS)) ||
               ((w_nb != '0) && ((|(io.imask & ~w_lanes)) || !io.imask[0]));
  end

  ebu_rank u_rank (
    .i_mask  (w_emask),
    .o_rank  (w_rank),
    .o_total (w_total)
  );

  assign w_adv    = !r_v2 || io.oready;
  assign w_iready = !r_v1 || w_adv;

  // Walk lanes downward so each start sees the next start above it (or the end of the beat).
  always_comb begin
    w_len     = '0;
    w_pos     = '0;
    w_len_err = 1'b0;
    w_next    = r_nb;
    w_full    = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      w_full = w_next - cnt_t'(i);
      if (r_emask[i]) begin
        w_pos[r_rank[i]] = pos_t'(i);
        w_len[r_rank[i]] = w_full[WW-1:0];
        if (w_full > cnt_t'(LMAX)) w_len_err = 1'b1;
        w_next = cnt_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_emask <= '0;
      r_nb    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_rank  <= '0;
      r_total <= '0;
      r_v2    <= 1'b0;
      r_onum  <= '0;
      r_olen  <= '0;
      r_opos  <= '0;
      r_odata <= '0;
      r_oerr  <= 1'b0;
    end else begin
      if (w_adv) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_onum  <= r_total;
          r_olen  <= w_len;
          r_opos  <= w_pos;
          r_odata <= r_data;
          r_oerr  <= r_err || w_len_err;
        end
      end
      if (w_iready) begin
        r_v1 <= io.ivalid;
        if (io.ivalid) begin
          r_emask <= w_emask;
          r_nb    <= w_nb;
          r_data  <= io.idata;
          r_err   <= w_err_in;
          r_rank  <= w_rank;
          r_total <= w_total;
        end
      end
    end
  end

  assign io.iready = w_iready;
  assign io.ovalid = r_v2;
  assign io.onum   = r_onum;
  assign io.olen   = r_olen;
  assign io.opos   = r_opos;
  assign io.odata  = r_odata;
  assign io.oerr   = r_oerr;
endmodule
